dpram_fifo_ctrl: RTL and testbench

- Synchronous FIFO controller that drives the 8-bit, 64-location dual-port RAM directly upstream of it: port 1 is the write port, port 2 is the read port.
- Converts a valid/ready producer stream into RAM writes, and RAM reads into a valid/ready consumer stream.
- Absorbs the RAM's 1-cycle registered read latency with a 2-entry output skid buffer, giving 1 word/cycle sustained throughput.

---
 rtl/dpram_fifo_pkg.sv | 11 +
 rtl/dpram_fifo_ctrl_if.sv | 25 ++
 rtl/dpram_fifo_skid.sv | 47 ++++
 rtl/dpram_fifo_ctrl.sv | 126 ++++++++++++
 tb/tb_dpram_fifo_ctrl.sv | 229 ++++++++++++++++++++++
 5 files changed

// File: rtl/dpram_fifo_pkg.sv
// Shared constants and types for the dual-port-RAM FIFO controller and its skid buffer.
package dpram_fifo_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int ADDR_W_DEF = 6;
  localparam int DEPTH      = 1 << ADDR_W_DEF;
  localparam int SKID_DEPTH = 2;

  typedef logic [ADDR_W_DEF:0] level_t;

endpackage

// File: rtl/dpram_fifo_ctrl_if.sv
// Producer/consumer valid-ready stream bundle for dpram_fifo_ctrl.
interface dpram_fifo_ctrl_if
  import dpram_fifo_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
);

  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );

endinterface

// File: rtl/dpram_fifo_skid.sv
// Two-entry registered skid buffer catching RAM read data; head drives the consumer stream.
module dpram_fifo_skid
  import dpram_fifo_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cap_vld_p1,
  input  logic [DATA_W-1:0] cap_data_p1,
  input  logic              pop,
  output logic [DATA_W-1:0] head_data,
  output logic              head_vld,
  output logic [1:0]        occ
);

  logic [DATA_W-1:0] skid_p2 [SKID_DEPTH];
  logic              wr_idx;
  logic              rd_idx;
  logic [1:0]        occ_q;

  // Stage p1 -> p2: capture RAM read data; the credit rule upstream keeps occupancy <= 2
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SKID_DEPTH; i++) skid_p2[i] <= '0;
      wr_idx <= 1'b0;
      rd_idx <= 1'b0;
      occ_q  <= '0;
    end else begin
      if (cap_vld_p1) begin
        skid_p2[wr_idx] <= cap_data_p1;
        wr_idx          <= ~wr_idx;
      end
      if (pop) rd_idx <= ~rd_idx;
      case ({cap_vld_p1, pop})
        2'b10:   occ_q <= occ_q + 2'd1;
        2'b01:   occ_q <= occ_q - 2'd1;
        default: occ_q <= occ_q;
      endcase
    end
  end

  assign head_data = skid_p2[rd_idx];
  assign head_vld  = (occ_q != 2'd0);
  assign occ       = occ_q;

endmodule

// File: rtl/dpram_fifo_ctrl.sv
// FIFO controller over a 1-write/1-read dual-port RAM with a 2-entry output skid.
// Optional almost_full/almost_empty outputs are enabled by defining DPRAM_FIFO_ALMOST_EN.
module dpram_fifo_ctrl
  import dpram_fifo_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
`ifdef DPRAM_FIFO_ALMOST_EN
  ,
  parameter int AF_THRESH = 56,
  parameter int AE_THRESH = 8
`endif
) (
  input  logic                clk,
  input  logic                rst_n,
  dpram_fifo_ctrl_if.slave    strm,
  output logic [DATA_W-1:0]   ram_data1,
  output logic [ADDR_W-1:0]   ram_adr1,
  output logic                ram_we1,
  output logic [DATA_W-1:0]   ram_data2,
  output logic [ADDR_W-1:0]   ram_adr2,
  output logic                ram_we2,
  input  logic [DATA_W-1:0]   ram_q2,
  output logic [ADDR_W:0]     level,
  output logic                ovf_err
`ifdef DPRAM_FIFO_ALMOST_EN
  ,
  output logic                almost_full,
  output logic                almost_empty
`endif
);

  localparam int             DEPTH_L  = 1 << ADDR_W;
  localparam logic [ADDR_W:0] FULL_LVL = (ADDR_W + 1)'(DEPTH_L);

  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [ADDR_W:0]   level_q;
  logic [ADDR_W:0]   level_next;
  logic              inflight_vld_p1;
  logic              ovf_q;
  logic              in_ready_w;
  logic              push;
  logic              pop_out;
  logic              rd_issue;
  logic [2:0]        credit;
  logic [1:0]        skid_occ;
  logic              head_vld;
  logic [DATA_W-1:0] head_data;

  // in_ready looks only at registered level, so a same-cycle pop never frees a slot early
  assign in_ready_w = rst_n && (level_q != FULL_LVL);
  assign push       = strm.in_valid && in_ready_w;
  assign pop_out    = head_vld && strm.out_ready;

  // Words already in flight or held in the skid must leave room for one more read
  assign credit   = {2'b00, inflight_vld_p1} + {1'b0, skid_occ} - {2'b00, pop_out};
  assign rd_issue = (level_q != '0) && (credit < 3'(SKID_DEPTH));

  always_comb begin
    level_next = level_q;
    case ({push, rd_issue})
      2'b10:   level_next = level_q + 1'b1;
      2'b01:   level_next = level_q - 1'b1;
      default: level_next = level_q;
    endcase
  end

  // Stage p0 -> p1: pointer/level update and read issue into the RAM's registered port
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr          <= '0;
      rd_ptr          <= '0;
      level_q         <= '0;
      inflight_vld_p1 <= 1'b0;
      ovf_q           <= 1'b0;
    end else begin
      if (push)     wr_ptr <= wr_ptr + 1'b1;
      if (rd_issue) rd_ptr <= rd_ptr + 1'b1;
      level_q         <= level_next;
      inflight_vld_p1 <= rd_issue;
      if (strm.in_valid && !in_ready_w) ovf_q <= 1'b1;
    end
  end

  dpram_fifo_skid #(
    .DATA_W (DATA_W)
  ) u_skid (
    .clk         (clk),
    .rst_n       (rst_n),
    .cap_vld_p1  (inflight_vld_p1),
    .cap_data_p1 (ram_q2),
    .pop         (pop_out),
    .head_data   (head_data),
    .head_vld    (head_vld),
    .occ         (skid_occ)
  );

  assign strm.in_ready  = in_ready_w;
  assign strm.out_valid = head_vld;
  assign strm.out_data  = head_data;

  assign ram_data1 = strm.in_data;
  assign ram_adr1  = wr_ptr;
  assign ram_we1   = push;
  assign ram_data2 = '0;
  assign ram_adr2  = rd_ptr;
  assign ram_we2   = 1'b0;

  assign level   = level_q;
  assign ovf_err = ovf_q;

`ifdef DPRAM_FIFO_ALMOST_EN
  // Stage p0 -> p1: thresholds track the level that becomes visible on the same edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      almost_full  <= 1'b0;
      almost_empty <= 1'b1;
    end else begin
      almost_full  <= (level_next >= (ADDR_W + 1)'(AF_THRESH));
      almost_empty <= (level_next <= (ADDR_W + 1)'(AE_THRESH));
    end
  end
`endif

endmodule

// File: tb/tb_dpram_fifo_ctrl.sv
// Directed bench for dpram_fifo_ctrl with a behavioural RAM and an in-order data scoreboard.
module tb_dpram_fifo_ctrl;
  import dpram_fifo_pkg::*;

  logic        clk;
  logic        rst_n;
  logic [7:0]  ram_data1;
  logic [5:0]  ram_adr1;
  logic        ram_we1;
  logic [7:0]  ram_data2;
  logic [5:0]  ram_adr2;
  logic        ram_we2;
  logic [7:0]  ram_q2;
  level_t      level;
  logic        ovf_err;
`ifdef DPRAM_FIFO_ALMOST_EN
  logic        almost_full;
  logic        almost_empty;
`endif

  dpram_fifo_ctrl_if #(.DATA_W(8)) bus ();

  dpram_fifo_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .strm      (bus),
    .ram_data1 (ram_data1),
    .ram_adr1  (ram_adr1),
    .ram_we1   (ram_we1),
    .ram_data2 (ram_data2),
    .ram_adr2  (ram_adr2),
    .ram_we2   (ram_we2),
    .ram_q2    (ram_q2),
    .level     (level),
    .ovf_err   (ovf_err)
`ifdef DPRAM_FIFO_ALMOST_EN
    ,
    .almost_full  (almost_full),
    .almost_empty (almost_empty)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural dual-port RAM with registered read on port 2
  logic [7:0] ram [DEPTH];
  always @(posedge clk) begin
    if (ram_we1) ram[ram_adr1] <= ram_data1;
    ram_q2 <= ram[ram_adr2];
  end

  int         n_chk = 0;
  int         n_pass = 0;
  int         n_push = 0;
  int         max_lvl = 0;
  logic [7:0] sbq [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  task automatic step(input logic iv, input logic [7:0] id, input logic ordy);
    @(negedge clk);
    bus.in_valid  = iv;
    bus.in_data   = id;
    bus.out_ready = ordy;
    #1;
    if (int'(level) > max_lvl) max_lvl = int'(level);
    if (bus.out_valid && bus.out_ready) begin
      chk("sb_has_entry", 32'(sbq.size() != 0), 32'd1);
      if (sbq.size() != 0) chk("out_data", 32'(bus.out_data), 32'(sbq.pop_front()));
    end
    if (bus.in_valid && bus.in_ready) begin
      sbq.push_back(bus.in_data);
      n_push++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int gaps;
    int pushes_before;
    int guard;

    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;

    // Reset state
    step(1'b0, 8'h00, 1'b0);
    step(1'b1, 8'h11, 1'b0);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_out_data", 32'(bus.out_data), 32'h00);
    chk("rst_level", 32'(level), 32'd0);
    chk("rst_ovf", 32'(ovf_err), 32'd0);
    chk("rst_we1", 32'(ram_we1), 32'd0);
    chk("ram_we2_tied", 32'(ram_we2), 32'd0);
    chk("ram_data2_tied", 32'(ram_data2), 32'd0);
    @(negedge clk);
    bus.in_valid = 1'b0;
    rst_n = 1'b1;
    #1;
    chk("post_rst_in_ready", 32'(bus.in_ready), 32'd1);

    // Single word latency
    step(1'b1, 8'hA5, 1'b1);
    chk("single_we1", 32'(ram_we1), 32'd1);
    chk("single_adr1", 32'(ram_adr1), 32'd0);
    chk("single_data1", 32'(ram_data1), 32'hA5);
    step(1'b0, 8'h00, 1'b1);
    chk("single_adr2", 32'(ram_adr2), 32'd0);
    chk("single_level1", 32'(level), 32'd1);
    chk("single_we1_idle", 32'(ram_we1), 32'd0);
    step(1'b0, 8'h00, 1'b1);
    chk("single_ov_early", 32'(bus.out_valid), 32'd0);
    chk("single_level0", 32'(level), 32'd0);
    step(1'b0, 8'h00, 1'b1);
    chk("single_ov", 32'(bus.out_valid), 32'd1);
    chk("single_od", 32'(bus.out_data), 32'hA5);
    step(1'b0, 8'h00, 1'b1);
    chk("single_ov_after", 32'(bus.out_valid), 32'd0);

    // Fill to 64 in RAM plus 2 in skid
    pushes_before = n_push;
    for (int i = 0; i < 66; i++) step(1'b1, 8'(i), 1'b0);
    chk("fill_accepted", 32'(n_push - pushes_before), 32'd66);
    step(1'b0, 8'h00, 1'b0);
    step(1'b0, 8'h00, 1'b0);
    chk("full_level", 32'(level), 32'd64);
    chk("full_in_ready", 32'(bus.in_ready), 32'd0);
    chk("full_ovf_clear", 32'(ovf_err), 32'd0);
    chk("full_head", 32'(bus.out_data), 32'h00);
    step(1'b1, 8'hEE, 1'b0);
    chk("ovf_no_write", 32'(ram_we1), 32'd0);
    step(1'b0, 8'h00, 1'b0);
    chk("ovf_set", 32'(ovf_err), 32'd1);
    chk("ovf_level", 32'(level), 32'd64);
    chk("ovf_head_hold", 32'(bus.out_data), 32'h00);

    // Drain at full rate
    gaps = 0;
    for (int i = 0; i < 66; i++) begin
      step(1'b0, 8'h00, 1'b1);
      if (!bus.out_valid) gaps++;
    end
    chk("drain_gaps", 32'(gaps), 32'd0);
    step(1'b0, 8'h00, 1'b1);
    chk("drain_ov", 32'(bus.out_valid), 32'd0);
    chk("drain_level", 32'(level), 32'd0);
    chk("drain_sb_empty", 32'(sbq.size()), 32'd0);

    // Random streaming across several pointer wraps
    for (int i = 0; i < 200; i++)
      step(1'($urandom_range(0, 9) < 9), 8'($urandom), 1'($urandom_range(0, 1)));
    guard = 0;
    while ((sbq.size() != 0 || bus.out_valid) && guard < 200) begin
      step(1'b0, 8'h00, 1'b1);
      guard++;
    end
    chk("stream_drained", 32'(sbq.size()), 32'd0);
    chk("stream_out_idle", 32'(bus.out_valid), 32'd0);
    chk("max_level_le_depth", 32'(max_lvl <= DEPTH), 32'd1);

    // Reset mid-stream
    for (int i = 0; i < 22; i++) step(1'b1, 8'(8'h80 + i), 1'b0);
    step(1'b0, 8'h00, 1'b0);
    step(1'b0, 8'h00, 1'b0);
    chk("mid_level", 32'(level), 32'd20);
    chk("mid_ov", 32'(bus.out_valid), 32'd1);
    chk("mid_ovf_sticky", 32'(ovf_err), 32'd1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_ov", 32'(bus.out_valid), 32'd0);
    chk("mid_rst_level", 32'(level), 32'd0);
    chk("mid_rst_ovf", 32'(ovf_err), 32'd0);
    chk("mid_rst_od", 32'(bus.out_data), 32'd0);
    chk("mid_rst_in_ready", 32'(bus.in_ready), 32'd0);
    sbq.delete();
    step(1'b0, 8'h00, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b1, 8'h5A, 1'b1);
    chk("post_rst_adr1", 32'(ram_adr1), 32'd0);
    step(1'b0, 8'h00, 1'b1);
    step(1'b0, 8'h00, 1'b1);
    step(1'b0, 8'h00, 1'b1);
    chk("post_rst_ov", 32'(bus.out_valid), 32'd1);
    chk("post_rst_od", 32'(bus.out_data), 32'h5A);
    step(1'b0, 8'h00, 1'b1);

`ifdef DPRAM_FIFO_ALMOST_EN
    chk("ae_idle", 32'(almost_empty), 32'd1);
    for (int i = 0; i < 60; i++) step(1'b1, 8'(i * 3), 1'b0);
    step(1'b0, 8'h00, 1'b0);
    chk("af_level", 32'(level), 32'd58);
    chk("af_set", 32'(almost_full), 32'd1);
    chk("ae_clear", 32'(almost_empty), 32'd0);
    guard = 0;
    while (level > 8 && guard < 100) begin
      step(1'b0, 8'h00, 1'b1);
      guard++;
    end
    chk("ae_level", 32'(level), 32'd8);
    chk("ae_set", 32'(almost_empty), 32'd1);
    chk("af_clear", 32'(almost_full), 32'd0);
    guard = 0;
    while ((sbq.size() != 0 || bus.out_valid) && guard < 100) begin
      step(1'b0, 8'h00, 1'b1);
      guard++;
    end
    chk("almost_drained", 32'(sbq.size()), 32'd0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
